// File: rtl/wb_stage_regfile.sv
// ---------------------------------------------------------------------------
// wb_stage_regfile
//
// Write-back end of the MEM2WB pipeline register. It takes the registered WB
// control, ALU result, memory read data and destination index, selects the
// write-back value and commits it into a general register file with
// NUM_REGS entries. Register 0 is hardwired to zero. It serves the two
// ID-stage read ports with a same-cycle write-through bypass. It also exports
// the current write-back to the forwarding unit.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset (0 = reset)
//   WB_In       in   [1] RegWrite enable, [0] MemToReg select
//   destIn      in   write-back destination index
//   ALUResIn    in   ALU result from MEM2WB
//   memReadIn   in   memory read data from MEM2WB
//   src1/src2   in   ID read port indices
//   reg1/reg2   out  ID read port data (combinational, bypassed)
//   wbEnOut     out  write-back commits this cycle
//   wbDestOut   out  committed destination index (0 when idle)
//   wbValueOut  out  committed value (0 when idle)
//   wbCount     out  saturating count of committed writes since reset
// ---------------------------------------------------------------------------
module wb_stage_regfile #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        WB_In,
    input  logic [ADDR_W-1:0] destIn,
    input  logic [DATA_W-1:0] ALUResIn,
    input  logic [DATA_W-1:0] memReadIn,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    output logic              wbEnOut,
    output logic [ADDR_W-1:0] wbDestOut,
    output logic [DATA_W-1:0] wbValueOut,
    output logic [31:0]       wbCount
);

    // -----------------------------------------------------------------------
    // Write-back selection and commit qualification
    // -----------------------------------------------------------------------
    logic              reg_write;
    logic              mem_to_reg;
    logic              commit;
    logic [DATA_W-1:0] wb_value;

    assign reg_write  = WB_In[1];
    assign mem_to_reg = WB_In[0];

    always_comb begin
        wb_value = mem_to_reg ? memReadIn : ALUResIn;
        // Writes aimed at register 0 are dropped entirely, so they neither
        // update state nor show up on the forwarding interface.
        commit   = reg_write && (destIn != '0);
    end

    // -----------------------------------------------------------------------
    // Register file state
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [31:0]       wb_count_q;
    logic [31:0]       wb_count_d;

    always_comb begin
        regs_d = regs_q;
        if (commit) begin
            regs_d[destIn] = wb_value;
        end
    end

    always_comb begin
        wb_count_d = wb_count_q;
        // Saturate rather than wrap so a long run never reports a small count.
        if (commit && (wb_count_q != 32'hFFFF_FFFF)) begin
            wb_count_d = wb_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
            wb_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wb_count_q <= wb_count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Read ports with write-through bypass
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] reg1_d;
    logic [DATA_W-1:0] reg2_d;

    always_comb begin
        if (src1 == '0) begin
            reg1_d = '0;
        end else if (commit && (src1 == destIn)) begin
            reg1_d = wb_value;
        end else begin
            reg1_d = regs_q[src1];
        end
    end

    always_comb begin
        if (src2 == '0) begin
            reg2_d = '0;
        end else if (commit && (src2 == destIn)) begin
            reg2_d = wb_value;
        end else begin
            reg2_d = regs_q[src2];
        end
    end

    assign reg1 = reg1_d;
    assign reg2 = reg2_d;

    // -----------------------------------------------------------------------
    // Forwarding interface and counter export
    // -----------------------------------------------------------------------
    always_comb begin
        wbEnOut    = commit;
        wbDestOut  = commit ? destIn : '0;
        wbValueOut = commit ? wb_value : '0;
    end

    assign wbCount = wb_count_q;

    // -----------------------------------------------------------------------
    // Protocol check: RegWrite must be known whenever out of reset.
    // -----------------------------------------------------------------------
    a_reg_write_known : assert property (
        @(posedge clk) disable iff (!rst) !$isunknown(WB_In[1])
    ) else $error("wb_stage_regfile: WB_In[1] is X/Z outside reset");

endmodule

// File: tb/tb_wb_stage_regfile.sv
module tb_wb_stage_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic [1:0]        WB_In;
    logic [ADDR_W-1:0] destIn;
    logic [DATA_W-1:0] ALUResIn;
    logic [DATA_W-1:0] memReadIn;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic              wbEnOut;
    logic [ADDR_W-1:0] wbDestOut;
    logic [DATA_W-1:0] wbValueOut;
    logic [31:0]       wbCount;

    wb_stage_regfile #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .WB_In     (WB_In),
        .destIn    (destIn),
        .ALUResIn  (ALUResIn),
        .memReadIn (memReadIn),
        .src1      (src1),
        .src2      (src2),
        .reg1      (reg1),
        .reg2      (reg2),
        .wbEnOut   (wbEnOut),
        .wbDestOut (wbDestOut),
        .wbValueOut(wbValueOut),
        .wbCount   (wbCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output selectors for scoreboard entries
    localparam int SEL_REG1  = 0;
    localparam int SEL_REG2  = 1;
    localparam int SEL_WBEN  = 2;
    localparam int SEL_WBDST = 3;
    localparam int SEL_WBVAL = 4;
    localparam int SEL_COUNT = 5;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 1'b0;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_REG1:  return reg1;
            SEL_REG2:  return reg2;
            SEL_WBEN:  return {31'd0, wbEnOut};
            SEL_WBDST: return {27'd0, wbDestOut};
            SEL_WBVAL: return wbValueOut;
            default:   return wbCount;
        endcase
    endfunction

    // Monitor: the DUT is combinational on its outputs, so it presents a
    // settled response at every falling edge; pop everything queued for it.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e   = exp_q.pop_front();
            act = observe(e.sel);
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        exp_q.push_back(e);
    endtask

    // Apply a new input vector shortly after the rising edge.
    task automatic drive(input logic [1:0] wb, input logic [4:0] dest,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [4:0] s1, input logic [4:0] s2);
        @(posedge clk);
        #1;
        WB_In     = wb;
        destIn    = dest;
        ALUResIn  = alu;
        memReadIn = mem;
        src1      = s1;
        src2      = s2;
    endtask

    initial begin
        rst = 1'b0; WB_In = 2'b00; destIn = '0; ALUResIn = '0; memReadIn = '0;
        src1 = 5'd5; src2 = 5'd0;

        // Reset state
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd5, 5'd7);
        expect_val("rst_reg1", SEL_REG1, 32'h0);
        expect_val("rst_reg2", SEL_REG2, 32'h0);
        expect_val("rst_count", SEL_COUNT, 32'h0);
        expect_val("rst_wben", SEL_WBEN, 32'h0);
        @(posedge clk); #1; rst = 1'b1;

        // ALU write to r5, visible through the bypass before the edge
        drive(2'b10, 5'd5, 32'h0000_1234, 32'h5555_5555, 5'd5, 5'd0);
        expect_val("alu_bypass_reg1", SEL_REG1, 32'h0000_1234);
        expect_val("alu_wben", SEL_WBEN, 32'h1);
        expect_val("alu_wbdest", SEL_WBDST, 32'd5);
        expect_val("alu_wbval", SEL_WBVAL, 32'h0000_1234);
        expect_val("alu_count_pre", SEL_COUNT, 32'h0);
        drive(2'b00, 5'd5, 32'h0, 32'h0, 5'd5, 5'd0);
        expect_val("alu_reg1", SEL_REG1, 32'h0000_1234);
        expect_val("alu_count", SEL_COUNT, 32'd1);
        expect_val("idle_wbval", SEL_WBVAL, 32'h0);
        expect_val("idle_wbdest", SEL_WBDST, 32'h0);

        // Memory write to r7 selects memReadIn
        drive(2'b11, 5'd7, 32'h0000_0001, 32'hDEAD_BEEF, 5'd7, 5'd5);
        expect_val("mem_wbval", SEL_WBVAL, 32'hDEAD_BEEF);
        expect_val("mem_bypass_reg1", SEL_REG1, 32'hDEAD_BEEF);
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd7, 5'd5);
        expect_val("mem_reg1", SEL_REG1, 32'hDEAD_BEEF);
        expect_val("mem_reg2_r5", SEL_REG2, 32'h0000_1234);
        expect_val("mem_count", SEL_COUNT, 32'd2);

        // Both ports bypass the same destination
        drive(2'b10, 5'd9, 32'h0000_00AA, 32'h0, 5'd9, 5'd9);
        expect_val("byp_reg1", SEL_REG1, 32'h0000_00AA);
        expect_val("byp_reg2", SEL_REG2, 32'h0000_00AA);
        expect_val("byp_wben", SEL_WBEN, 32'h1);
        expect_val("byp_wbdest", SEL_WBDST, 32'd9);
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd9, 5'd7);
        expect_val("byp_reg1_after", SEL_REG1, 32'h0000_00AA);
        expect_val("byp_count", SEL_COUNT, 32'd3);

        // Write aimed at r0 is dropped
        drive(2'b10, 5'd0, 32'h0000_FFFF, 32'h0, 5'd0, 5'd0);
        expect_val("r0_reg1", SEL_REG1, 32'h0);
        expect_val("r0_reg2", SEL_REG2, 32'h0);
        expect_val("r0_wben", SEL_WBEN, 32'h0);
        expect_val("r0_wbval", SEL_WBVAL, 32'h0);
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd0, 5'd9);
        expect_val("r0_reg1_after", SEL_REG1, 32'h0);
        expect_val("r0_count", SEL_COUNT, 32'd3);

        // r3 = 0x3333, then RegWrite=0 must leave it alone
        drive(2'b10, 5'd3, 32'h0000_3333, 32'h0, 5'd3, 5'd0);
        drive(2'b01, 5'd3, 32'h0000_9999, 32'h0000_6666, 5'd3, 5'd0);
        expect_val("nw_reg1", SEL_REG1, 32'h0000_3333);
        expect_val("nw_wbval", SEL_WBVAL, 32'h0);
        expect_val("nw_wben", SEL_WBEN, 32'h0);
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd3, 5'd0);
        expect_val("nw_reg1_after", SEL_REG1, 32'h0000_3333);
        expect_val("nw_count", SEL_COUNT, 32'd4);

        // Asynchronous reset mid-write: state clears, bypass and forwarding follow inputs
        drive(2'b10, 5'd5, 32'h0000_0077, 32'h0, 5'd7, 5'd5);
        rst = 1'b0;
        expect_val("arst_reg1", SEL_REG1, 32'h0);
        expect_val("arst_reg2_bypass", SEL_REG2, 32'h0000_0077);
        expect_val("arst_count", SEL_COUNT, 32'h0);
        expect_val("arst_wben", SEL_WBEN, 32'h1);
        expect_val("arst_wbdest", SEL_WBDST, 32'd5);
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd3, 5'd5);
        rst = 1'b1;
        expect_val("arst_r3", SEL_REG1, 32'h0);
        expect_val("arst_no_write_r5", SEL_REG2, 32'h0);
        expect_val("arst_count_after", SEL_COUNT, 32'h0);

        // Saturation: preload the counter just below its ceiling
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        dut.wb_count_q = 32'hFFFF_FFFE;
        drive(2'b10, 5'd10, 32'h1, 32'h0, 5'd10, 5'd0);
        expect_val("sat_pre", SEL_COUNT, 32'hFFFF_FFFE);
        drive(2'b10, 5'd10, 32'h2, 32'h0, 5'd10, 5'd0);
        expect_val("sat_top", SEL_COUNT, 32'hFFFF_FFFF);
        drive(2'b10, 5'd10, 32'h3, 32'h0, 5'd10, 5'd0);
        expect_val("sat_hold", SEL_COUNT, 32'hFFFF_FFFF);
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd10, 5'd0);
        expect_val("sat_hold2", SEL_COUNT, 32'hFFFF_FFFF);
        expect_val("sat_r10", SEL_REG1, 32'h3);

        // Let the monitor drain, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: got timeout, expected completion");
            $fatal(1, "timeout");
        end
    end

endmodule
